// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage -- RV32 memory stage sitting directly after the EX-stage ALU.
//
// The ALU result is either the effective address of a load/store or, for every
// other instruction, the value to write back. Memory accesses go out over a
// single-outstanding req/ack port with byte enables; load data is realigned
// and sign/zero-extended before writeback. Misaligned or illegal-width
// accesses never reach memory and instead raise a one-cycle exception pulse.
//
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   ex_valid                   EX stage presents a valid instruction
//   ex_mem_read/ex_mem_write   load / store (mutually exclusive)
//   ex_funct3                  RISC-V width/sign code
//   ex_alu_result              address (mem ops) or writeback value (others)
//   ex_store_data              rs2 value for stores
//   ex_rd                      destination register
//   dmem_req/we/addr/wdata/be  registered data-memory request, held until ack
//   dmem_ack, dmem_rdata       memory completion and read data
//   stall                      combinational: upstream must hold ex_* stable
//   wb_valid/wb_rd/wb_data     registered writeback, one-cycle pulse per result
//   lsu_exc/exc_cause/exc_addr registered exception pulse, cause and address
//                              (cause 0=load misaligned, 1=store misaligned,
//                               2=illegal width)

module lsu_mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_funct3,
    input  logic [DATA_WIDTH-1:0] ex_alu_result,
    input  logic [DATA_WIDTH-1:0] ex_store_data,
    input  logic [4:0]            ex_rd,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  lsu_exc,
    output logic [1:0]            exc_cause,
    output logic [ADDR_WIDTH-1:0] exc_addr
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [1:0] CAUSE_LD_MISALIGN = 2'd0;
    localparam logic [1:0] CAUSE_ST_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_ILL_WIDTH   = 2'd2;

    // Store lane formatting: returns {byte_enables, replicated_write_data}.
    function automatic logic [35:0] store_lanes(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] data);
        logic [3:0]  be;
        logic [31:0] wd;
        case (f3)
            3'd0: begin
                be = 4'b0001 << off;
                wd = {4{data[7:0]}};
            end
            3'd1: begin
                be = 4'b0011 << off;
                wd = {2{data[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = data;
            end
        endcase
        return {be, wd};
    endfunction

    // Load extraction: pick the byte/half at the latched offset and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'd0:    res = {{24{b[7]}}, b};
            3'd4:    res = {24'd0, b};
            3'd1:    res = {{16{h[15]}}, h};
            3'd5:    res = {16'd0, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    logic [0:0]  state_r;
    logic        is_load_r;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic [4:0]  rd_r;

    logic        is_mem_s;
    logic        width_ok_s;
    logic        misalign_s;
    logic        idle_s;
    logic        accept_s;
    logic [35:0] lanes_s;

    // Width legality and alignment decode of the instruction presented by EX.
    always_comb begin
        width_ok_s = 1'b0;
        misalign_s = 1'b0;
        case (ex_funct3)
            3'd0: begin
                width_ok_s = 1'b1;
                misalign_s = 1'b0;
            end
            3'd1: begin
                width_ok_s = 1'b1;
                misalign_s = ex_alu_result[0];
            end
            3'd2: begin
                width_ok_s = 1'b1;
                misalign_s = |ex_alu_result[1:0];
            end
            // Unsigned variants exist only for loads.
            3'd4: begin
                width_ok_s = ex_mem_read;
                misalign_s = 1'b0;
            end
            3'd5: begin
                width_ok_s = ex_mem_read;
                misalign_s = ex_alu_result[0];
            end
            default: begin
                width_ok_s = 1'b0;
                misalign_s = 1'b0;
            end
        endcase
    end

    assign is_mem_s = ex_mem_read | ex_mem_write;
    assign idle_s   = (state_r == ST_IDLE);
    assign accept_s = idle_s & ex_valid & is_mem_s & width_ok_s & ~misalign_s;
    assign lanes_s  = store_lanes(ex_funct3, ex_alu_result[1:0], ex_store_data);

    assign stall = accept_s | (~idle_s & ~dmem_ack);

    // Access FSM plus all registered memory, writeback and exception outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            is_load_r  <= 1'b0;
            funct3_r   <= 3'd0;
            off_r      <= 2'd0;
            rd_r       <= 5'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= 4'b0000;
            wb_valid   <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= '0;
            lsu_exc    <= 1'b0;
            exc_cause  <= 2'd0;
            exc_addr   <= '0;
        end else begin
            // Result and exception strobes are single-cycle pulses.
            wb_valid <= 1'b0;
            lsu_exc  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ex_valid) begin
                        if (!is_mem_s) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= ex_rd;
                            wb_data  <= ex_alu_result;
                        end else if (accept_s) begin
                            state_r   <= ST_BUSY;
                            dmem_req  <= 1'b1;
                            dmem_we   <= ex_mem_write;
                            dmem_addr <= {ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
                            if (ex_mem_write) begin
                                dmem_be    <= lanes_s[35:32];
                                dmem_wdata <= lanes_s[31:0];
                            end else begin
                                dmem_be    <= 4'b1111;
                                dmem_wdata <= '0;
                            end
                            is_load_r <= ex_mem_read;
                            funct3_r  <= ex_funct3;
                            off_r     <= ex_alu_result[1:0];
                            rd_r      <= ex_rd;
                        end else begin
                            lsu_exc  <= 1'b1;
                            exc_addr <= ex_alu_result[ADDR_WIDTH-1:0];
                            if (!width_ok_s) begin
                                exc_cause <= CAUSE_ILL_WIDTH;
                            end else if (ex_mem_write) begin
                                exc_cause <= CAUSE_ST_MISALIGN;
                            end else begin
                                exc_cause <= CAUSE_LD_MISALIGN;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    // Request fields stay frozen until the memory acknowledges.
                    if (dmem_ack) begin
                        state_r  <= ST_IDLE;
                        dmem_req <= 1'b0;
                        if (is_load_r) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_r;
                            wb_data  <= load_extract(funct3_r, off_r, dmem_rdata);
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage. Inputs are driven 1 ns after
// the rising edge; registered outputs are checked there, the combinational
// stall 1 ns later.

module tb_lsu_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_exc;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    int errs;
    int checks;

    lsu_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lsu_exc(lsu_exc), .exc_cause(exc_cause), .exc_addr(exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata, input int delay,
                           input logic [31:0] exp_data);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_funct3 = f3; ex_alu_result = addr; ex_rd = rd;
        #1;
        check_val({tag, " stall_accept"}, stall, 1);
        tick();
        check_val({tag, " req"}, dmem_req, 1);
        check_val({tag, " we"}, dmem_we, 0);
        check_val({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
        check_val({tag, " be"}, dmem_be, 4'b1111);
        for (int i = 0; i < delay; i++) begin
            check_val({tag, " stall_wait"}, stall, 1);
            tick();
            check_val({tag, " req_hold"}, dmem_req, 1);
            check_val({tag, " addr_hold"}, dmem_addr, {addr[31:2], 2'b00});
            check_val({tag, " wb_early"}, wb_valid, 0);
        end
        dmem_ack = 1'b1; dmem_rdata = rdata;
        #1;
        check_val({tag, " stall_ack"}, stall, 0);
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        idle_inputs();
        check_val({tag, " req_drop"}, dmem_req, 0);
        check_val({tag, " wb_valid"}, wb_valid, 1);
        check_val({tag, " wb_rd"}, wb_rd, rd);
        check_val({tag, " wb_data"}, wb_data, exp_data);
        tick();
        check_val({tag, " wb_pulse"}, wb_valid, 0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b1;
        ex_funct3 = f3; ex_alu_result = addr; ex_store_data = data; ex_rd = 5'd0;
        #1;
        check_val({tag, " stall_accept"}, stall, 1);
        tick();
        check_val({tag, " req"}, dmem_req, 1);
        check_val({tag, " we"}, dmem_we, 1);
        check_val({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
        check_val({tag, " be"}, dmem_be, exp_be);
        check_val({tag, " wdata"}, dmem_wdata, exp_wdata);
        dmem_ack = 1'b1;
        #1;
        check_val({tag, " stall_ack"}, stall, 0);
        tick();
        dmem_ack = 1'b0;
        idle_inputs();
        check_val({tag, " req_drop"}, dmem_req, 0);
        check_val({tag, " no_wb"}, wb_valid, 0);
    endtask

    task automatic do_exc(input string tag, input logic rd_op, input logic wr_op,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [1:0] exp_cause);
        ex_valid = 1'b1; ex_mem_read = rd_op; ex_mem_write = wr_op;
        ex_funct3 = f3; ex_alu_result = addr; ex_rd = 5'd3;
        #1;
        check_val({tag, " no_stall"}, stall, 0);
        tick();
        idle_inputs();
        check_val({tag, " no_req"}, dmem_req, 0);
        check_val({tag, " exc"}, lsu_exc, 1);
        check_val({tag, " cause"}, exc_cause, exp_cause);
        check_val({tag, " exc_addr"}, exc_addr, addr);
        check_val({tag, " no_wb"}, wb_valid, 0);
        tick();
        check_val({tag, " exc_pulse"}, lsu_exc, 0);
    endtask

    initial begin
        errs = 0;
        checks = 0;
        rst_n = 1'b0;
        idle_inputs();
        ex_funct3 = 3'd0; ex_alu_result = 32'h0; ex_store_data = 32'h0; ex_rd = 5'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        tick();
        tick();
        check_val("rst req", dmem_req, 0);
        check_val("rst be", dmem_be, 0);
        check_val("rst addr", dmem_addr, 0);
        check_val("rst wb_valid", wb_valid, 0);
        check_val("rst wb_data", wb_data, 0);
        check_val("rst exc", lsu_exc, 0);
        check_val("rst stall", stall, 0);
        rst_n = 1'b1;
        tick();

        // Word load with three wait cycles: stall spans accept + 3 waits.
        do_load("lw_wait", 3'd2, 32'h0000_1000, 5'd5, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);
        do_load("lb_neg",  3'd0, 32'h0000_1003, 5'd6, 32'h8012_3456, 0, 32'hFFFF_FF80);
        do_load("lbu",     3'd4, 32'h0000_1003, 5'd7, 32'h8012_3456, 0, 32'h0000_0080);
        do_load("lhu",     3'd5, 32'h0000_1002, 5'd8, 32'h8012_3456, 1, 32'h0000_8012);
        do_load("lh_neg",  3'd1, 32'h0000_1002, 5'd9, 32'h8012_3456, 0, 32'hFFFF_8012);
        do_load("lb_off0", 3'd0, 32'h0000_1000, 5'd0, 32'h8012_3456, 0, 32'h0000_0056);

        do_store("sh_hi", 3'd1, 32'h0000_2002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        do_store("sb_1",  3'd0, 32'h0000_2001, 32'h0000_0077, 4'b0010, 32'h7777_7777);
        do_store("sw",    3'd2, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        do_exc("lw_mis", 1'b1, 1'b0, 3'd2, 32'h0000_1001, 2'd0);
        do_exc("sw_mis", 1'b0, 1'b1, 3'd2, 32'h0000_1002, 2'd1);
        do_exc("ld_ill", 1'b1, 1'b0, 3'd3, 32'h0000_1000, 2'd2);
        do_exc("sh_mis", 1'b0, 1'b1, 3'd1, 32'h0000_2001, 2'd1);
        do_exc("st_ill", 1'b0, 1'b1, 3'd4, 32'h0000_2000, 2'd2);

        // A memory op with ex_valid low must be ignored.
        ex_valid = 1'b0; ex_mem_read = 1'b1; ex_funct3 = 3'd2; ex_alu_result = 32'h0000_3000;
        #1;
        check_val("invalid stall", stall, 0);
        tick();
        check_val("invalid req", dmem_req, 0);
        idle_inputs();

        // Back-to-back ALU results, one per cycle.
        for (int i = 1; i <= 3; i++) begin
            ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
            ex_alu_result = i; ex_rd = 5'(i + 10);
            #1;
            check_val("alu stall", stall, 0);
            tick();
            check_val("alu wb_valid", wb_valid, 1);
            check_val("alu wb_data", wb_data, i);
            check_val("alu wb_rd", wb_rd, i + 10);
        end
        idle_inputs();
        tick();
        check_val("alu wb_pulse", wb_valid, 0);

        // Reset during an outstanding load abandons it.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'd2;
        ex_alu_result = 32'h0000_4000; ex_rd = 5'd4;
        tick();
        check_val("rstmid req", dmem_req, 1);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_val("rstmid req_drop", dmem_req, 0);
        check_val("rstmid wb_valid", wb_valid, 0);
        check_val("rstmid stall", stall, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_val("rstmid after wb", wb_valid, 0);
        do_load("lw_post_rst", 3'd2, 32'h0000_4000, 5'd4, 32'h1357_9BDF, 0, 32'h1357_9BDF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
